biriscv_exec_pipe: RTL and testbench

- Parametrised next-generation integer execute unit: RV32I/RV64I ALU, branch resolution, AUIPC/LUI, JAL/JALR link value.
- Results pass through a configurable elastic result pipeline with valid/ready flow control and flush.
- Adds RVC-aware link/fall-through (+2), misaligned-target detection and backpressure.
- Sits between issue (operand read) and writeback/branch-predictor update.

---
 rtl/biriscv_exec_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_biriscv_exec_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_exec_pipe.sv
// Integer execute unit: RV32I/RV64I ALU, branch resolution, LUI/AUIPC and
// JAL/JALR link values. The result of each accepted instruction passes through
// an elastic pipeline of RESULT_STAGES registered stages with valid/ready
// handshaking and a flush. Taken branches also raise an early redirect in the
// issue cycle.
module biriscv_exec_pipe #(
    parameter int XLEN          = 32,
    parameter int RESULT_STAGES = 1,
    parameter int SUPPORT_RVC   = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            opcode_valid_i,
    output logic            opcode_ready_o,
    input  logic [31:0]     opcode_opcode_i,
    input  logic [XLEN-1:0] opcode_pc_i,
    input  logic            opcode_rvc_i,
    input  logic [4:0]      opcode_rd_idx_i,
    input  logic [4:0]      opcode_ra_idx_i,
    input  logic [4:0]      opcode_rb_idx_i,
    input  logic [XLEN-1:0] opcode_ra_operand_i,
    input  logic [XLEN-1:0] opcode_rb_operand_i,
    input  logic            flush_i,
    input  logic            out_ready_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] writeback_value_o,
    output logic [4:0]      writeback_rd_idx_o,
    output logic            branch_request_o,
    output logic            branch_is_taken_o,
    output logic            branch_is_not_taken_o,
    output logic            branch_is_call_o,
    output logic            branch_is_ret_o,
    output logic            branch_is_jmp_o,
    output logic [XLEN-1:0] branch_source_o,
    output logic [XLEN-1:0] branch_pc_o,
    output logic            branch_misaligned_o,
    output logic            branch_d_request_o,
    output logic [XLEN-1:0] branch_d_pc_o
);

    localparam int SHW = (XLEN == 64) ? 6 : 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] value;
        logic [4:0]      rd;
        logic            request;
        logic            taken;
        logic            not_taken;
        logic            call;
        logic            ret;
        logic            jmp;
        logic            misaligned;
        logic [XLEN-1:0] source;
        logic [XLEN-1:0] pc;
    } result_t;

    // Register-source index has no role in execution.
    logic unused_rb_idx;
    assign unused_rb_idx = ^opcode_rb_idx_i;

    logic [6:0]      op;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] a, b, alu_b, alu, link, target, jalr_sum;
    logic [SHW-1:0]  shamt;
    logic            cond, fire;
    result_t         ex;

    assign op = opcode_opcode_i[6:0];
    assign f3 = opcode_opcode_i[14:12];
    assign a  = opcode_ra_operand_i;
    assign b  = opcode_rb_operand_i;

    assign imm_i = {{(XLEN-11){opcode_opcode_i[31]}}, opcode_opcode_i[30:20]};
    assign imm_b = {{(XLEN-12){opcode_opcode_i[31]}}, opcode_opcode_i[7],
                    opcode_opcode_i[30:25], opcode_opcode_i[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){opcode_opcode_i[31]}}, opcode_opcode_i[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){opcode_opcode_i[31]}}, opcode_opcode_i[19:12],
                    opcode_opcode_i[20], opcode_opcode_i[30:21], 1'b0};

    // Immediate forms take the shift amount from imm[5:0]/imm[4:0].
    assign alu_b    = (op == OP_IMM) ? imm_i : b;
    assign shamt    = alu_b[SHW-1:0];
    assign link     = opcode_pc_i + (((opcode_rvc_i != 1'b0) && (SUPPORT_RVC != 0)) ? XLEN'(2) : XLEN'(4));
    assign jalr_sum = a + imm_i;

    // ALU result for OP / OP-IMM; bit 30 selects SUB (register form only) and SRA.
    always_comb begin
        alu = '0;
        case (f3)
            3'b000: alu = (op == OP_REG && opcode_opcode_i[30]) ? a - alu_b : a + alu_b;
            3'b001: alu = a << shamt;
            3'b010: alu[0] = $signed(a) < $signed(alu_b);
            3'b011: alu[0] = a < alu_b;
            3'b100: alu = a ^ alu_b;
            3'b101: alu = opcode_opcode_i[30] ? XLEN'($signed(a) >>> shamt) : a >> shamt;
            3'b110: alu = a | alu_b;
            default: alu = a & alu_b;
        endcase
    end

    // Conditional branch outcome over the full XLEN operands.
    always_comb begin
        cond = 1'b0;
        case (f3)
            3'b000: cond = (a == b);
            3'b001: cond = (a != b);
            3'b100: cond = $signed(a) < $signed(b);
            3'b101: cond = $signed(a) >= $signed(b);
            3'b110: cond = a < b;
            3'b111: cond = a >= b;
            default: cond = 1'b0;
        endcase
    end

    // Decode into the result record plus the redirect target.
    always_comb begin
        ex     = '0;
        target = '0;
        ex.rd  = opcode_rd_idx_i;
        case (op)
            OP_LUI:   ex.value = imm_u;
            OP_AUIPC: ex.value = opcode_pc_i + imm_u;
            OP_IMM:   ex.value = alu;
            OP_REG:   if ({opcode_opcode_i[31], opcode_opcode_i[29:25]} == 6'd0) ex.value = alu;
            OP_JAL: begin
                ex.value   = link;
                ex.request = 1'b1;
                ex.taken   = 1'b1;
                ex.call    = (opcode_rd_idx_i == 5'd1);
                target     = opcode_pc_i + imm_j;
            end
            OP_JALR: begin
                ex.value   = link;
                ex.request = 1'b1;
                ex.taken   = 1'b1;
                ex.call    = (opcode_rd_idx_i == 5'd1);
                ex.ret     = (opcode_ra_idx_i == 5'd1) && (imm_i == '0);
                target     = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_BRANCH: begin
                // f3 = 010/011 are not branches and stay unrecognised.
                if (f3[2:1] != 2'b01) begin
                    ex.value     = link;
                    ex.request   = 1'b1;
                    ex.taken     = cond;
                    ex.not_taken = ~cond;
                    target       = opcode_pc_i + imm_b;
                end
            end
            default: ;
        endcase
        if (ex.request) begin
            ex.jmp        = (op != OP_BRANCH) && !ex.call && !ex.ret;
            ex.misaligned = ex.taken && target[1] && (SUPPORT_RVC == 0);
            ex.source     = opcode_pc_i;
            ex.pc         = ex.taken ? target : link;
        end
    end

    logic [RESULT_STAGES-1:0] vld_d, vld_q;
    logic [RESULT_STAGES:0]   free;
    result_t                  res_d [RESULT_STAGES];
    result_t                  res_q [RESULT_STAGES];

    // Early redirect is only meaningful for an accepted, legal taken target.
    assign fire               = opcode_valid_i & opcode_ready_o & ~flush_i & rst_ni;
    assign branch_d_request_o = fire & ex.taken & ~ex.misaligned;
    assign branch_d_pc_o      = rst_ni ? target : '0;

    // Elastic stage control: free[k] means stage k can accept this cycle
    // (empty, or its contents move on). Flush wins over any load.
    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < RESULT_STAGES; k++) res_d[k] = res_q[k];
        free = '0;
        free[RESULT_STAGES] = out_ready_i;
        for (int k = RESULT_STAGES - 1; k >= 0; k--) free[k] = ~vld_q[k] | free[k+1];
        if (free[0]) begin
            vld_d[0] = fire;
            if (fire) res_d[0] = ex;
        end
        for (int k = 1; k < RESULT_STAGES; k++) begin
            if (free[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) res_d[k] = res_q[k-1];
            end
        end
        if (flush_i) vld_d = '0;
    end

    // Stage registers; contents are cleared too so outputs read zero in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int k = 0; k < RESULT_STAGES; k++) res_q[k] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < RESULT_STAGES; k++) res_q[k] <= res_d[k];
        end
    end

    assign opcode_ready_o        = free[0];
    assign out_valid_o           = vld_q[RESULT_STAGES-1];
    assign writeback_value_o     = res_q[RESULT_STAGES-1].value;
    assign writeback_rd_idx_o    = res_q[RESULT_STAGES-1].rd;
    assign branch_request_o      = res_q[RESULT_STAGES-1].request;
    assign branch_is_taken_o     = res_q[RESULT_STAGES-1].taken;
    assign branch_is_not_taken_o = res_q[RESULT_STAGES-1].not_taken;
    assign branch_is_call_o      = res_q[RESULT_STAGES-1].call;
    assign branch_is_ret_o       = res_q[RESULT_STAGES-1].ret;
    assign branch_is_jmp_o       = res_q[RESULT_STAGES-1].jmp;
    assign branch_source_o       = res_q[RESULT_STAGES-1].source;
    assign branch_pc_o           = res_q[RESULT_STAGES-1].pc;
    assign branch_misaligned_o   = res_q[RESULT_STAGES-1].misaligned;

endmodule

// File: tb/tb_biriscv_exec_pipe.sv
// Directed bench: instance A is 2 stages with RVC, instance B is 3 stages
// without RVC. Both see the same issue stream; each has its own out_ready.
module tb_biriscv_exec_pipe;

    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] AUI  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_n, op_valid, flush, op_rvc, ordy_a, ordy_b;
    logic [31:0] op_ins, op_pc, ra_v, rb_v;
    logic [4:0]  rd_idx, ra_idx, rb_idx;

    logic        rdy_a, ov_a, breq_a, tk_a, ntk_a, call_a, ret_a, jmp_a, mis_a, dreq_a;
    logic [31:0] wb_a, bsrc_a, bpc_a, dpc_a;
    logic [4:0]  rd_a;
    logic        rdy_b, ov_b, breq_b, tk_b, ntk_b, call_b, ret_b, jmp_b, mis_b, dreq_b;
    logic [31:0] wb_b, bsrc_b, bpc_b, dpc_b;
    logic [4:0]  rd_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    biriscv_exec_pipe #(.XLEN(32), .RESULT_STAGES(2), .SUPPORT_RVC(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .opcode_valid_i(op_valid), .opcode_ready_o(rdy_a),
        .opcode_opcode_i(op_ins), .opcode_pc_i(op_pc), .opcode_rvc_i(op_rvc),
        .opcode_rd_idx_i(rd_idx), .opcode_ra_idx_i(ra_idx), .opcode_rb_idx_i(rb_idx),
        .opcode_ra_operand_i(ra_v), .opcode_rb_operand_i(rb_v), .flush_i(flush),
        .out_ready_i(ordy_a), .out_valid_o(ov_a), .writeback_value_o(wb_a),
        .writeback_rd_idx_o(rd_a), .branch_request_o(breq_a), .branch_is_taken_o(tk_a),
        .branch_is_not_taken_o(ntk_a), .branch_is_call_o(call_a), .branch_is_ret_o(ret_a),
        .branch_is_jmp_o(jmp_a), .branch_source_o(bsrc_a), .branch_pc_o(bpc_a),
        .branch_misaligned_o(mis_a), .branch_d_request_o(dreq_a), .branch_d_pc_o(dpc_a));

    biriscv_exec_pipe #(.XLEN(32), .RESULT_STAGES(3), .SUPPORT_RVC(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .opcode_valid_i(op_valid), .opcode_ready_o(rdy_b),
        .opcode_opcode_i(op_ins), .opcode_pc_i(op_pc), .opcode_rvc_i(op_rvc),
        .opcode_rd_idx_i(rd_idx), .opcode_ra_idx_i(ra_idx), .opcode_rb_idx_i(rb_idx),
        .opcode_ra_operand_i(ra_v), .opcode_rb_operand_i(rb_v), .flush_i(flush),
        .out_ready_i(ordy_b), .out_valid_o(ov_b), .writeback_value_o(wb_b),
        .writeback_rd_idx_o(rd_b), .branch_request_o(breq_b), .branch_is_taken_o(tk_b),
        .branch_is_not_taken_o(ntk_b), .branch_is_call_o(call_b), .branch_is_ret_o(ret_b),
        .branch_is_jmp_o(jmp_b), .branch_source_o(bsrc_b), .branch_pc_o(bpc_b),
        .branch_misaligned_o(mis_b), .branch_d_request_o(dreq_b), .branch_d_pc_o(dpc_b));

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[19:0], rd, op};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic rvc,
                         input logic [31:0] a, input logic [31:0] b);
        op_ins = ins; op_pc = pc; op_rvc = rvc; ra_v = a; rb_v = b;
        rd_idx = ins[11:7]; ra_idx = ins[19:15]; rb_idx = ins[24:20];
        op_valid = 1'b1;
    endtask

    // One ALU instruction through both instances, checking each at its output.
    task automatic alu_vec(input string tag, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        issue(ins, 32'h1000, 1'b0, a, b);
        tick;
        op_valid = 1'b0;
        tick;
        chk1({tag, "_vld_a"}, ov_a, 1'b1);
        chkw({tag, "_a"}, wb_a, exp);
        chk1({tag, "_breq_a"}, breq_a, 1'b0);
        tick;
        chkw({tag, "_b"}, wb_b, exp);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ordy_a = 1'b1; ordy_b = 1'b1;
        op_valid = 1'b0; op_ins = '0; op_pc = '0; op_rvc = 1'b0;
        ra_v = '0; rb_v = '0; rd_idx = '0; ra_idx = '0; rb_idx = '0;

        // Reset: all outputs zero even with a taken jump presented, ready high.
        issue(enc_j(32'h40, 5'd1), 32'h200, 1'b0, '0, '0);
        tick;
        chk1("rst_ready_a", rdy_a, 1'b1);
        chk1("rst_ready_b", rdy_b, 1'b1);
        chk1("rst_outs_a", |{ov_a, wb_a, rd_a, breq_a, tk_a, ntk_a, call_a, ret_a, jmp_a,
                             bsrc_a, bpc_a, mis_a, dreq_a, dpc_a}, 1'b0);
        chk1("rst_outs_b", |{ov_b, wb_b, rd_b, breq_b, tk_b, ntk_b, call_b, ret_b, jmp_b,
                             bsrc_b, bpc_b, mis_b, dreq_b, dpc_b}, 1'b0);
        op_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;

        // ADDI overflow; latency 2 on A, 3 on B.
        issue(enc_i(1, 5'd1, 3'd0, 5'd3, OPI), 32'h1000, 1'b0, 32'h7FFF_FFFF, '0);
        tick;
        op_valid = 1'b0;
        chk1("addi_lat1_a", ov_a, 1'b0);
        tick;
        chk1("addi_vld_a", ov_a, 1'b1);
        chkw("addi_val_a", wb_a, 32'h8000_0000);
        chkw("addi_rd_a", {27'd0, rd_a}, 32'd3);
        chk1("addi_lat2_b", ov_b, 1'b0);
        tick;
        chk1("addi_drain_a", ov_a, 1'b0);
        chk1("addi_vld_b", ov_b, 1'b1);
        chkw("addi_val_b", wb_b, 32'h8000_0000);

        alu_vec("sub",   enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_vec("slt",   enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd4), 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_vec("sltu",  enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd4), 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_vec("srai",  enc_i(32'h404, 5'd1, 3'b101, 5'd4, OPI), 32'h8000_0000, '0, 32'hF800_0000);
        alu_vec("srl",   enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd4), 32'h8000_0000, 32'h24, 32'h0800_0000);
        alu_vec("slli",  enc_i(8, 5'd1, 3'b001, 5'd4, OPI), 32'h00FF_00FF, '0, 32'hFF00_FF00);
        alu_vec("xori",  enc_i(-1, 5'd1, 3'b100, 5'd4, OPI), 32'h0F0F_0F0F, '0, 32'hF0F0_F0F0);
        alu_vec("or",    enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd4), 32'hF0, 32'h0F, 32'hFF);
        alu_vec("and",   enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd4), 32'hF0, 32'h3C, 32'h30);
        alu_vec("lui",   enc_u(32'h12345, 5'd4, LUI), '0, '0, 32'h1234_5000);
        alu_vec("auipc", enc_u(32'hFFFFF, 5'd4, AUI), '0, '0, 32'h0);
        alu_vec("unrec", 32'h0000_007F, 32'd9, 32'd9, 32'h0);

        // BLT signed taken: early redirect plus final-stage info.
        issue(enc_b(32'h20, 5'd2, 5'd1, 3'b100), 32'h100, 1'b0, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk1("blt_dreq_a", dreq_a, 1'b1);
        chkw("blt_dpc_a", dpc_a, 32'h120);
        chk1("blt_dreq_b", dreq_b, 1'b1);
        tick; op_valid = 1'b0; tick;
        chk1("blt_req", breq_a, 1'b1);
        chk1("blt_tk", tk_a, 1'b1);
        chk1("blt_ntk", ntk_a, 1'b0);
        chkw("blt_pc", bpc_a, 32'h120);
        chkw("blt_src", bsrc_a, 32'h100);
        chkw("blt_link", wb_a, 32'h104);
        chk1("blt_jmp", jmp_a, 1'b0);
        tick;

        // BLTU same operands: unsigned compare, not taken.
        issue(enc_b(32'h20, 5'd2, 5'd1, 3'b110), 32'h100, 1'b0, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk1("bltu_dreq", dreq_a, 1'b0);
        tick; op_valid = 1'b0; tick;
        chk1("bltu_tk", tk_a, 1'b0);
        chk1("bltu_ntk", ntk_a, 1'b1);
        chkw("bltu_pc", bpc_a, 32'h104);
        tick;

        // BEQ backwards and BGEU unsigned taken.
        issue(enc_b(-8, 5'd2, 5'd1, 3'b000), 32'h300, 1'b0, 32'd5, 32'd5);
        #1;
        chkw("beq_dpc", dpc_a, 32'h2F8);
        tick; op_valid = 1'b0; tick;
        chkw("beq_pc", bpc_a, 32'h2F8);
        tick;
        issue(enc_b(32'h10, 5'd2, 5'd1, 3'b111), 32'h400, 1'b0, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk1("bgeu_dreq", dreq_a, 1'b1);
        tick; op_valid = 1'b0; tick;
        chkw("bgeu_pc", bpc_a, 32'h410);
        tick;

        // JAL x1 compressed: +2 link on A, +4 on B (RVC unsupported).
        issue(enc_j(32'h40, 5'd1), 32'h200, 1'b1, '0, '0);
        #1;
        chkw("jal_dpc", dpc_a, 32'h240);
        tick; op_valid = 1'b0; tick;
        chkw("jal_link_a", wb_a, 32'h202);
        chk1("jal_call", call_a, 1'b1);
        chk1("jal_jmp", jmp_a, 1'b0);
        chkw("jal_pc", bpc_a, 32'h240);
        tick;
        chkw("jal_link_b", wb_b, 32'h204);

        // JALR to a 2-byte aligned target: legal on A, misaligned on B.
        issue(enc_i(0, 5'd5, 3'd0, 5'd0, JALR), 32'h500, 1'b0, 32'h1002, '0);
        #1;
        chk1("jalr_dreq_a", dreq_a, 1'b1);
        chk1("jalr_dreq_b", dreq_b, 1'b0);
        tick; op_valid = 1'b0; tick;
        chk1("jalr_mis_a", mis_a, 1'b0);
        chk1("jalr_jmp_a", jmp_a, 1'b1);
        tick;
        chk1("jalr_mis_b", mis_b, 1'b1);
        chk1("jalr_tk_b", tk_b, 1'b1);
        chkw("jalr_pc_b", bpc_b, 32'h1002);

        // JALR target bit 0 cleared; ra=x1 with nonzero imm is not a return.
        issue(enc_i(32'h10, 5'd1, 3'd0, 5'd0, JALR), 32'h500, 1'b0, 32'h1001, '0);
        #1;
        chkw("jalr_clr_dpc", dpc_a, 32'h1010);
        tick; op_valid = 1'b0; tick;
        chk1("jalr_clr_ret", ret_a, 1'b0);
        tick;
        issue(enc_i(0, 5'd1, 3'd0, 5'd0, JALR), 32'h500, 1'b0, 32'h2000, '0);
        tick; op_valid = 1'b0; tick;
        chk1("ret_ret", ret_a, 1'b1);
        chk1("ret_jmp", jmp_a, 1'b0);
        chk1("ret_call", call_a, 1'b0);
        tick; tick; tick;

        // Backpressure on B: three accepts, then ready drops and output holds.
        ordy_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(enc_i(1, 5'd1, 3'd0, 5'(10 + i), OPI), 32'h1000, 1'b0, 32'(i * 16), '0);
            #1;
            chk1($sformatf("stall_rdy%0d", i), rdy_b, (i < 3) ? 1'b1 : 1'b0);
            if (i < 3) tick;
        end
        chk1("stall_vld", ov_b, 1'b1);
        chkw("stall_val0", wb_b, 32'h1);
        tick;
        chk1("stall_rdy_hold", rdy_b, 1'b0);
        chkw("stall_val1", wb_b, 32'h1);
        chkw("stall_rd", {27'd0, rd_b}, 32'd10);
        ordy_b = 1'b1;
        #1;
        chk1("stall_rel_rdy", rdy_b, 1'b1);
        tick; op_valid = 1'b0;
        chkw("drain1", wb_b, 32'h11);
        tick;
        chkw("drain2", wb_b, 32'h21);
        tick;
        chkw("drain3", wb_b, 32'h31);
        chkw("drain3_rd", {27'd0, rd_b}, 32'd13);
        tick;
        chk1("drain_empty", ov_b, 1'b0);
        tick; tick;

        // Flush with two in flight and a same-cycle taken jump.
        issue(enc_i(1, 5'd1, 3'd0, 5'd5, OPI), 32'h1000, 1'b0, 32'h50, '0);
        tick;
        issue(enc_i(1, 5'd1, 3'd0, 5'd6, OPI), 32'h1000, 1'b0, 32'h60, '0);
        tick;
        issue(enc_j(32'h40, 5'd0), 32'h600, 1'b0, '0, '0);
        flush = 1'b1;
        #1;
        chk1("flush_dreq_a", dreq_a, 1'b0);
        chk1("flush_dreq_b", dreq_b, 1'b0);
        tick;
        flush = 1'b0; op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("flush_vld_a%0d", i), ov_a, 1'b0);
            chk1($sformatf("flush_vld_b%0d", i), ov_b, 1'b0);
            tick;
        end

        // Reset mid-stream: outputs zero at once, nothing emerges afterwards.
        issue(enc_i(1, 5'd1, 3'd0, 5'd7, OPI), 32'h1000, 1'b0, 32'h70, '0);
        tick;
        issue(enc_j(32'h40, 5'd1), 32'h700, 1'b0, '0, '0);
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mrst_ready_a", rdy_a, 1'b1);
        chk1("mrst_outs_a", |{ov_a, wb_a, rd_a, breq_a, tk_a, ntk_a, call_a, ret_a, jmp_a,
                              bsrc_a, bpc_a, mis_a, dreq_a, dpc_a}, 1'b0);
        chk1("mrst_outs_b", |{ov_b, wb_b, rd_b, breq_b, tk_b, ntk_b, call_b, ret_b, jmp_b,
                              bsrc_b, bpc_b, mis_b, dreq_b, dpc_b}, 1'b0);
        op_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk1($sformatf("mrst_vld%0d", i), ov_a | ov_b, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
